regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the core's 2-read/1-write register file.
- Adds a second write port for the long-latency unit (mul/div) writeback.
- Adds write-enable-qualified bypass and a per-register scoreboard (busy bits plus busy counter) so ID-stage hazard logic can stall on pending long-latency results.
- Sits in the ID stage of the pipeline. WB and the long-latency unit write into it.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 hardwired to zero (never written, never busy); 0 = register 0 is ordinary

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_data2  out  DATA_W  read port 2 data (combinational)
rd_busy1  out  1  register at rd_addr1 has a pending long-latency result
rd_busy2  out  1  same, for rd_addr2
wr0_en  in  1  pipeline WB write enable
wr0_addr  in  ADDR_W  WB destination
wr0_data  in  DATA_W  WB data
wr1_en  in  1  long-latency writeback enable; also clears busy
wr1_addr  in  ADDR_W  long-latency destination
wr1_data  in  DATA_W  long-latency data
iss_en  in  1  long-latency op issued; sets busy on iss_addr
iss_addr  in  ADDR_W  destination of issued op
busy_cnt  out  ADDR_W+1  number of registers currently busy (registered)
sb_err  out  1  sticky scoreboard error (see Optional Feature)

Behaviour:
- Reset:
  - reset low asynchronously clears all registers to 0, all busy bits to 0, busy_cnt to 0, and sb_err to 0.
  - The block holds this state while reset is low.
  - reset asserted mid-operation discards all pending busy state.
- "Protected address": address 0 when ZERO_REG=1.
- Writes:
  - At the clk edge, wrN_en with a non-protected address stores wrN_data.
  - Writes to a protected address are ignored.
  - If wr0 and wr1 target the same address in the same cycle, wr0 wins; the younger instruction is at WB.
- Reads (combinational, per port):
  - Protected address -> 0.
  - Else if wr0_en and wr0_addr == rd_addr -> wr0_data.
  - Else if wr1_en and wr1_addr == rd_addr -> wr1_data.
  - Else the stored value.
  - Bypass requires the enable. A matching address with the enable low does not forward.
- Busy bits (scoreboard):
  - set = iss_en and iss_addr is non-protected.
  - clr = wr1_en and wr1_addr is non-protected.
  - At the edge: busy[iss_addr] <= 1 if set; busy[wr1_addr] <= 0 if clr.
  - If both act on the same address, set wins and the bit stays busy (new issue after retire).
  - wr0 never affects busy.
- rd_busyN:
  - 0 for a protected address.
  - 0 when wr1_en and wr1_addr == rd_addrN in the current cycle; the result is being forwarded.
  - Otherwise busy[rd_addrN].
  - iss_en in the current cycle does not affect rd_busyN until the next cycle.
- busy_cnt:
  - Increments when set targets a non-busy register.
  - Decrements when clr targets a busy register that is not simultaneously set.
  - A set and clr on different addresses in the same cycle can yield a net 0.
  - Always equals the popcount of busy bits.
  - Maximum 2**ADDR_W - ZERO_REG; no wrap.
- Latency: a write is visible on a read port in the same cycle via bypass and from storage from the next cycle.

Optional Feature:
Macro: REGFILE_SB_CHECK_EN
- Defined:
  - sb_err sets, and holds until reset, when iss_en targets an already-busy register that is not being cleared in the same cycle (WAW on a pending result).
  - sb_err also sets when wr1_en targets a non-busy, non-protected register (spurious retire).
  - Register and busy updates proceed normally despite the error.
- Not defined: sb_err is tied to 0 and no check logic is built. The port is kept for interface stability.

Test Plan:
1. Reset low mid-run with busy[5]=1 and r7=0x1234 -> rd_data for r7 = 0, rd_busy = 0, busy_cnt = 0 immediately, before any clk edge.
2. wr0_en=1, addr 3, data 0xDEADBEEF; rd_addr1=3 in the same cycle -> rd_data1=0xDEADBEEF. Next cycle with wr0_en=0 -> still 0xDEADBEEF. Then wr0_en=0, addr 3, data 0x1 -> no forward, reads 0xDEADBEEF.
3. Write 0xFFFFFFFF to addr 0 on both ports and iss_en addr 0 -> rd_data 0, rd_busy 0, busy_cnt 0.
4. iss_en addr 8 -> next cycle rd_busy1(8)=1, busy_cnt=1. Later wr1_en addr 8, data 0x55 -> same cycle rd_busy1=0, rd_data1=0x55. Next cycle busy_cnt=0.
5. Same cycle: iss_en addr 9 while wr1_en addr 9 (9 busy) -> busy[9] stays 1, busy_cnt unchanged. Then wr0 and wr1 both to addr 4 with 0xA / 0xB -> r4 = 0xA.
6. With REGFILE_SB_CHECK_EN: iss addr 10 twice without retire -> sb_err=1 after the second edge, staying 1. wr1 to non-busy addr 11 in a fresh run -> sb_err=1. Without the macro -> sb_err stays 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 2-write register file with an issue scoreboard.
// Write port 0 carries the pipeline WB result. Write port 1 carries the long-latency (mul/div) result.
// Each register has a busy bit. It is set when a long-latency op issues to that register
// and cleared when that op's result is written back.
// Optional build macro REGFILE_SB_CHECK_EN enables the sticky sb_err checker.
// When the macro is undefined, sb_err is tied low.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr0_en,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   input  logic              wr1_en,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic [ADDR_W:0]   busy_cnt,
   output logic              sb_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CW    = ADDR_W + 1;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              set_w, clr_w, inc_w, dec_w;

   // Register 0 is read-only zero and never busy when ZERO_REG is set
   function automatic logic is_prot(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign set_w = iss_en && !is_prot(iss_addr);
   assign clr_w = wr1_en && !is_prot(wr1_addr);

   // Storage update: the wr0 assignment is placed last so that wr0 wins an address collision
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         if (wr1_en && !is_prot(wr1_addr)) regs_q[wr1_addr] <= wr1_data;
         if (wr0_en && !is_prot(wr0_addr)) regs_q[wr0_addr] <= wr0_data;
      end
   end

   // Read ports: storage, then wr1 bypass, then wr0 bypass (highest priority); a protected address reads 0
   always_comb begin
      rd_data1 = regs_q[rd_addr1];
      if (wr1_en && (wr1_addr == rd_addr1)) rd_data1 = wr1_data;
      if (wr0_en && (wr0_addr == rd_addr1)) rd_data1 = wr0_data;
      if (is_prot(rd_addr1)) rd_data1 = '0;
      rd_data2 = regs_q[rd_addr2];
      if (wr1_en && (wr1_addr == rd_addr2)) rd_data2 = wr1_data;
      if (wr0_en && (wr0_addr == rd_addr2)) rd_data2 = wr0_data;
      if (is_prot(rd_addr2)) rd_data2 = '0;
   end

   // Busy lookup: a result forwarded this cycle on wr1 already satisfies the reader
   always_comb begin
      rd_busy1 = busy_q[rd_addr1] && !(wr1_en && (wr1_addr == rd_addr1)) && !is_prot(rd_addr1);
      rd_busy2 = busy_q[rd_addr2] && !(wr1_en && (wr1_addr == rd_addr2)) && !is_prot(rd_addr2);
   end

   // Scoreboard next state: clear first and set last, so a new issue wins over a retire to the same register
   always_comb begin
      busy_d = busy_q;
      if (clr_w) busy_d[wr1_addr] = 1'b0;
      if (set_w) busy_d[iss_addr] = 1'b1;
      inc_w  = set_w && !busy_q[iss_addr];
      dec_w  = clr_w && busy_q[wr1_addr] && !(set_w && (iss_addr == wr1_addr));
      cnt_d  = cnt_q + CW'(inc_w) - CW'(dec_w);
   end

   // Scoreboard state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_cnt = cnt_q;

`ifdef REGFILE_SB_CHECK_EN
   logic err_q, err_d, waw_w, spur_w;

   // Error detection: WAW on a pending result that is not retiring this cycle, or a retire to a non-busy register
   always_comb begin
      waw_w  = set_w && busy_q[iss_addr] && !(clr_w && (wr1_addr == iss_addr));
      spur_w = clr_w && !busy_q[wr1_addr];
      err_d  = err_q || waw_w || spur_w;
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign sb_err = err_q;
`else
   assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
// Expected sb_err follows REGFILE_SB_CHECK_EN when the bench is compiled with that macro.
module tb_regfile_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

`ifdef REGFILE_SB_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] rd_addr1, rd_addr2;
   logic [DATA_W-1:0] rd_data1, rd_data2;
   logic              rd_busy1, rd_busy2;
   logic              wr0_en, wr1_en, iss_en;
   logic [ADDR_W-1:0] wr0_addr, wr1_addr, iss_addr;
   logic [DATA_W-1:0] wr0_data, wr1_data;
   logic [ADDR_W:0]   busy_cnt;
   logic              sb_err;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .busy_cnt(busy_cnt), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      tick();
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      rd_addr1 = '0; rd_addr2 = '0;
      wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
      wr0_data = '0; wr1_data = '0;
      do_reset();
      chk("rst_cnt", busy_cnt, 0);
      chk("rst_err", sb_err, 0);

      // 1: async reset mid-run
      wr0_en = 1; wr0_addr = 7; wr0_data = 32'h1234;
      iss_en = 1; iss_addr = 5;
      tick(); idle();
      rd_addr1 = 7; rd_addr2 = 5; #1;
      chk("pre_r7", rd_data1, 32'h1234);
      chk("pre_busy5", rd_busy2, 1);
      chk("pre_cnt", busy_cnt, 1);
      reset = 1'b0; #1;
      chk("arst_r7", rd_data1, 0);
      chk("arst_busy5", rd_busy2, 0);
      chk("arst_cnt", busy_cnt, 0);
      tick();
      chk("arst_hold_cnt", busy_cnt, 0);
      reset = 1'b1; #1;

      // 2: wr0 bypass and storage; no forwarding without the enable
      wr0_en = 1; wr0_addr = 3; wr0_data = 32'hDEADBEEF; rd_addr1 = 3; #1;
      chk("byp0_r3", rd_data1, 32'hDEADBEEF);
      tick(); idle(); #1;
      chk("stor_r3", rd_data1, 32'hDEADBEEF);
      wr0_addr = 3; wr0_data = 32'h1; #1;
      chk("nofwd_r3", rd_data1, 32'hDEADBEEF);
      tick();
      chk("nofwd_r3_next", rd_data1, 32'hDEADBEEF);

      // 3: register 0 is protected
      wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
      wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFFFFFF;
      iss_en = 1; iss_addr = 0; rd_addr1 = 0; rd_addr2 = 0; #1;
      chk("r0_byp", rd_data1, 0);
      chk("r0_busy_now", rd_busy1, 0);
      tick(); idle(); #1;
      chk("r0_data", rd_data2, 0);
      chk("r0_busy", rd_busy2, 0);
      chk("r0_cnt", busy_cnt, 0);
      chk("r0_err", sb_err, 0);

      // 4: issue then retire on register 8
      iss_en = 1; iss_addr = 8; rd_addr1 = 8; #1;
      chk("iss8_same_cycle", rd_busy1, 0);
      tick(); idle(); #1;
      chk("iss8_busy", rd_busy1, 1);
      chk("iss8_cnt", busy_cnt, 1);
      wr1_en = 1; wr1_addr = 8; wr1_data = 32'h55; #1;
      chk("ret8_busy", rd_busy1, 0);
      chk("ret8_byp", rd_data1, 32'h55);
      chk("ret8_cnt_same", busy_cnt, 1);
      tick(); idle(); #1;
      chk("ret8_cnt", busy_cnt, 0);
      chk("ret8_data", rd_data1, 32'h55);
      chk("ret8_err", sb_err, 0);

      // 5: set wins over clear on the same register; wr0 wins over wr1
      iss_en = 1; iss_addr = 9;
      tick(); idle(); #1;
      chk("iss9_cnt", busy_cnt, 1);
      iss_en = 1; iss_addr = 9; wr1_en = 1; wr1_addr = 9; wr1_data = 32'h77;
      tick(); idle(); rd_addr2 = 9; #1;
      chk("setclr9_busy", rd_busy2, 1);
      chk("setclr9_cnt", busy_cnt, 1);
      chk("setclr9_data", rd_data2, 32'h77);
      chk("setclr9_err", sb_err, 0);
      wr0_en = 1; wr0_addr = 4; wr0_data = 32'hA;
      wr1_en = 1; wr1_addr = 4; wr1_data = 32'hB; rd_addr1 = 4; #1;
      chk("coll4_byp", rd_data1, 32'hA);
      tick(); idle(); #1;
      chk("coll4_stor", rd_data1, 32'hA);
      chk("spur4_err", sb_err, ERR_EXP);
      do_reset();
      chk("rst2_err", sb_err, 0);
      chk("rst2_cnt", busy_cnt, 0);

      // 6a: WAW on a pending result
      iss_en = 1; iss_addr = 10;
      tick(); #1;
      chk("waw_first_err", sb_err, 0);
      chk("waw_first_cnt", busy_cnt, 1);
      tick(); idle(); #1;
      chk("waw_err", sb_err, ERR_EXP);
      chk("waw_cnt", busy_cnt, 1);
      tick(); tick();
      chk("waw_err_sticky", sb_err, ERR_EXP);
      do_reset();

      // 6b: spurious retire, then set and clear on different registers
      wr1_en = 1; wr1_addr = 11; wr1_data = 32'h5;
      tick(); idle(); rd_addr1 = 11; #1;
      chk("spur11_err", sb_err, ERR_EXP);
      chk("spur11_data", rd_data1, 32'h5);
      chk("spur11_cnt", busy_cnt, 0);
      iss_en = 1; iss_addr = 12;
      tick(); idle(); #1;
      chk("iss12_cnt", busy_cnt, 1);
      iss_en = 1; iss_addr = 13; wr1_en = 1; wr1_addr = 12; wr1_data = 32'hC;
      tick(); idle(); rd_addr1 = 12; rd_addr2 = 13; #1;
      chk("net0_cnt", busy_cnt, 1);
      chk("net0_busy12", rd_busy1, 0);
      chk("net0_busy13", rd_busy2, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
